// File: rtl/select_grant_pkg.sv
// Shared types and helpers for the select_grant output-port arbiter.
package select_grant_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  // Bits needed to index 'value' items; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int width;
    int span;
    width = 0;
    span  = value - 1;
    while (span > 0) begin
      width = width + 1;
      span  = span >> 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/grant_rr_encoder.sv
// Round-robin one-hot encoder: picks the first set request at or after ptr, wrapping modulo N.
module grant_rr_encoder
  import select_grant_pkg::*;
#(
  parameter  int N  = 25,
  localparam int PW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int cand;

  // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/select_grant.sv
// Output-port grant stage: strict priority across levels, round-robin within a level,
// then holds the connection busy for the accepted transfer length.
module select_grant
  import select_grant_pkg::*;
#(
  parameter  int N   = 25,
  parameter  int P   = 8,
  parameter  int LW  = 8,
  localparam int PW  = (clog2(N) < 1) ? 1 : clog2(N),
  localparam int LVW = (clog2(P) < 1) ? 1 : clog2(P)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*P-1:0]  i_request,
  input  logic [N-1:0]    i_accept,
  input  logic [LW-1:0]   i_len,
  output logic [N-1:0]    o_grant,
  output logic [P-1:0]    o_priority,
  output logic [PW-1:0]   o_port,
  output logic            o_busy
);

  state_t         state;
  logic [PW-1:0]  ptr [P];
  logic [LW-1:0]  counter;
  logic [LVW-1:0] lvl_q;
  logic [PW-1:0]  win_q;

  logic [LVW-1:0] level;
  logic [N-1:0]   lvl_req;
  logic [N-1:0]   enc_grant;
  logic [PW-1:0]  enc_idx;
  logic           enc_valid;

  // Ascending scan, so the highest level with any request is the one left in 'level'.
  always_comb begin
    level = '0;
    for (int j = 0; j < P; j++) begin
      for (int i = 0; i < N; i++) begin
        if (i_request[i*P + j]) level = LVW'(j);
      end
    end
  end

  always_comb begin
    lvl_req = '0;
    for (int i = 0; i < N; i++) begin
      lvl_req[i] = i_request[i*P + int'(level)];
    end
  end

  grant_rr_encoder #(.N(N)) u_encoder (
    .req   (lvl_req),
    .ptr   (ptr[level]),
    .grant (enc_grant),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      // NOTE: ptr is a small bank of flops rather than a RAM, so it is cleared along with the rest of the state.
      for (int j = 0; j < P; j++) ptr[j] <= '0;
      counter    <= '0;
      lvl_q      <= '0;
      win_q      <= '0;
      o_grant    <= '0;
      o_priority <= '0;
      o_port     <= '0;
      o_busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enc_valid) begin
            o_grant    <= enc_grant;
            o_priority <= P'(1) << level;
            lvl_q      <= level;
            win_q      <= enc_idx;
            state      <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          o_grant    <= '0;
          o_priority <= '0;
          // Only an accept on the granted input counts; the rest of i_accept is ignored.
          if (|(i_accept & o_grant)) begin
            ptr[lvl_q] <= (win_q == PW'(N-1)) ? '0 : win_q + PW'(1);
            counter    <= (i_len == '0) ? LW'(1) : i_len;
            o_port     <= win_q;
            o_busy     <= 1'b1;
            state      <= ST_BUSY;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (counter == LW'(1)) begin
            counter <= '0;
            o_busy  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            counter <= counter - LW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_select_grant.sv
// Directed bench for select_grant with N=4, P=4, LW=8; expected values are hand-computed.
module tb_select_grant;
  import select_grant_pkg::*;

  localparam int N  = 4;
  localparam int P  = 4;
  localparam int LW = 8;

  logic            clk;
  logic            reset;
  logic [N*P-1:0]  i_request;
  logic [N-1:0]    i_accept;
  logic [LW-1:0]   i_len;
  logic [N-1:0]    o_grant;
  logic [P-1:0]    o_priority;
  logic [1:0]      o_port;
  logic            o_busy;

  int checks;
  int failures;
  int busy_cycles;

  select_grant #(.N(N), .P(P), .LW(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_request  (i_request),
    .i_accept   (i_accept),
    .i_len      (i_len),
    .o_grant    (o_grant),
    .o_priority (o_priority),
    .o_port     (o_port),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive busy cycles starting from the current one, bounded at 20.
  task automatic measure_busy(output int cycles);
    cycles = 0;
    for (int k = 0; k < 20 && o_busy; k++) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    i_request = '0;
    i_accept  = '0;
    i_len     = '0;
    tick();
    tick();
    check("rst_grant", o_grant, 0);
    check("rst_prio", o_priority, 0);
    check("rst_busy", o_busy, 0);
    check("rst_port", o_port, 0);
    check("rst_state", dut.state, ST_IDLE);

    // Inputs 1 and 3 at level 3.
    reset     = 1'b0;
    i_request = 16'h8080;
    tick();
    check("s1_grant", o_grant, 4'b0010);
    check("s1_prio", o_priority, 4'b1000);
    check("s1_busy_low", o_busy, 0);
    i_accept  = 4'b0010;
    i_len     = 8'd3;
    i_request = '0;
    tick();
    i_accept  = '0;
    check("s1_busy", o_busy, 1);
    check("s1_port", o_port, 1);
    check("s1_grant_off", o_grant, 0);
    check("s1_prio_off", o_priority, 0);
    check("s1_ptr3", dut.ptr[3], 2);
    measure_busy(busy_cycles);
    check("s1_len3", busy_cycles, 3);

    // Same requests; pointer now favours input 3, then wraps.
    i_request = 16'h8080;
    tick();
    check("s2_grant", o_grant, 4'b1000);
    i_accept  = 4'b1000;
    i_len     = 8'd1;
    i_request = '0;
    tick();
    i_accept  = '0;
    check("s2_port", o_port, 3);
    check("s2_ptr3_wrap", dut.ptr[3], 0);
    measure_busy(busy_cycles);
    check("s2_len1", busy_cycles, 1);

    // Input 0 at level 0, input 2 at level 2: level 2 wins.
    i_request = 16'h0401;
    tick();
    check("s3_grant", o_grant, 4'b0100);
    check("s3_prio", o_priority, 4'b0100);
    i_accept  = 4'b0100;
    i_len     = 8'd1;
    i_request = '0;
    tick();
    i_accept  = '0;
    check("s3_ptr0", dut.ptr[0], 0);
    check("s3_ptr2", dut.ptr[2], 3);
    check("s3_ptr3", dut.ptr[3], 0);
    measure_busy(busy_cycles);
    check("s3_len1", busy_cycles, 1);

    // No accept returns to IDLE without touching the pointer.
    i_request = 16'h8080;
    tick();
    check("s4_grant", o_grant, 4'b0010);
    i_accept = 4'b0000;
    tick();
    check("s4_idle_grant", o_grant, 0);
    check("s4_idle_busy", o_busy, 0);
    check("s4_state", dut.state, ST_IDLE);
    check("s4_ptr3", dut.ptr[3], 0);
    tick();
    check("s4_regrant", o_grant, 4'b0010);

    // Accept on a non-granted input is ignored.
    i_accept = 4'b0100;
    tick();
    check("s5_ignored_busy", o_busy, 0);
    check("s5_ignored_state", dut.state, ST_IDLE);
    i_accept = '0;
    tick();
    check("s5_regrant", o_grant, 4'b0010);

    // Zero length behaves as one cell.
    i_accept  = 4'b0010;
    i_len     = 8'd0;
    i_request = '0;
    tick();
    i_accept  = '0;
    check("s5_ptr3", dut.ptr[3], 2);
    measure_busy(busy_cycles);
    check("s5_len0", busy_cycles, 1);

    // Reset in the second BUSY cycle of a length-5 transfer.
    i_request = 16'h0002;
    tick();
    check("s6_grant", o_grant, 4'b0001);
    check("s6_prio", o_priority, 4'b0010);
    i_accept  = 4'b0001;
    i_len     = 8'd5;
    i_request = '0;
    tick();
    i_accept  = '0;
    check("s6_ptr1", dut.ptr[1], 1);
    tick();
    check("s6_busy_c2", o_busy, 1);
    reset = 1'b1;
    tick();
    check("s6_rst_busy", o_busy, 0);
    check("s6_rst_grant", o_grant, 0);
    check("s6_rst_prio", o_priority, 0);
    check("s6_rst_port", o_port, 0);
    check("s6_rst_state", dut.state, ST_IDLE);
    check("s6_rst_cnt", dut.counter, 0);
    check("s6_rst_ptr1", dut.ptr[1], 0);
    check("s6_rst_ptr2", dut.ptr[2], 0);
    check("s6_rst_ptr3", dut.ptr[3], 0);

    // First grant after reset release uses the cleared pointers.
    reset     = 1'b0;
    i_request = 16'h8080;
    tick();
    check("s7_grant", o_grant, 4'b0010);
    check("s7_prio", o_priority, 4'b1000);
    i_request = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
